// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision field definitions, FSM states and helpers
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 25;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ALIGN,
        ST_SUB,
        ST_NORM,
        ST_DONE
    } state_t;

    function automatic logic fp_sign(input logic [31:0] w);
        return w[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] w);
        return w[30:23];
    endfunction

    function automatic logic [FRAC_W-1:0] fp_frac(input logic [31:0] w);
        return w[22:0];
    endfunction

    // Guard zero on top, then the implicit leading one, then the stored fraction.
    function automatic logic [MANT_W-1:0] fp_mant(input logic [FRAC_W-1:0] frac);
        return {1'b0, 1'b1, frac};
    endfunction

    function automatic logic [31:0] fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_mag_swap.sv
// rtl/fp_mag_swap.sv - orders two operands by magnitude (exponent, then fraction)
module fp_mag_swap
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [FRAC_W-1:0] frac_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [FRAC_W-1:0] frac_b,
    output logic [EXP_W-1:0]  big_exp,
    output logic [MANT_W-1:0] big_mant,
    output logic [EXP_W-1:0]  small_exp,
    output logic [MANT_W-1:0] small_mant,
    output logic              swapped
);

    // Exponent sits above the fraction, so one wide compare orders by exponent first.
    assign swapped = {exp_b, frac_b} > {exp_a, frac_a};

    always_comb begin
        if (swapped) begin
            big_exp    = exp_b;
            big_mant   = fp_mant(frac_b);
            small_exp  = exp_a;
            small_mant = fp_mant(frac_a);
        end else begin
            big_exp    = exp_a;
            big_mant   = fp_mant(frac_a);
            small_exp  = exp_b;
            small_mant = fp_mant(frac_b);
        end
    end

endmodule

// File: rtl/fp_subtractor.sv
// rtl/fp_subtractor.sv - multi-cycle same-sign single-precision subtractor, truncating
module fp_subtractor
    import fp_pkg::*;
#(
    parameter int          ALIGN_LIMIT = 24,
    parameter logic [31:0] QNAN        = QNAN_WORD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        available,
    input  logic [4:0]  exception_f,
    output logic [31:0] diff,
    output logic        done
);

    localparam logic [EXP_W-1:0] LIMIT = EXP_W'(ALIGN_LIMIT);

    state_t             state;
    logic               sign_r;
    logic [4:0]         flags_r;
    logic [EXP_W-1:0]   exp_x, exp_y, d_r, exp_r;
    logic [MANT_W-1:0]  mant_x, mant_y, mant_r;

    logic [EXP_W-1:0]   sw_big_exp, sw_small_exp;
    logic [MANT_W-1:0]  sw_big_mant, sw_small_mant;
    logic               sw_swapped;
    logic [EXP_W-1:0]   exp_delta;
    logic [MANT_W-1:0]  sub_mant;

    fp_mag_swap u_mag_swap (
        .exp_a      (fp_exp(a)),
        .frac_a     (fp_frac(a)),
        .exp_b      (fp_exp(b)),
        .frac_b     (fp_frac(b)),
        .big_exp    (sw_big_exp),
        .big_mant   (sw_big_mant),
        .small_exp  (sw_small_exp),
        .small_mant (sw_small_mant),
        .swapped    (sw_swapped)
    );

    assign exp_delta = exp_x - exp_y;
    assign sub_mant  = mant_x - mant_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            diff    <= ZERO_WORD;
            done    <= 1'b0;
            sign_r  <= 1'b0;
            flags_r <= '0;
            exp_x   <= '0;
            exp_y   <= '0;
            mant_x  <= '0;
            mant_y  <= '0;
            d_r     <= '0;
            exp_r   <= '0;
            mant_r  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (available)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    exp_x   <= sw_big_exp;
                    mant_x  <= sw_big_mant;
                    exp_y   <= sw_small_exp;
                    mant_y  <= sw_small_mant;
                    sign_r  <= sw_swapped ? ~fp_sign(a) : fp_sign(a);
                    flags_r <= exception_f;
                    state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (|flags_r) begin
                        diff  <= QNAN;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (exp_delta >= LIMIT) begin
                        diff  <= fp_pack(sign_r, exp_x, mant_x[FRAC_W-1:0]);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (exp_delta == '0) begin
                        state <= ST_SUB;
                    end else begin
                        d_r   <= exp_delta;
                        state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    // The cycle doing the last shift also leaves, so alignment costs d cycles.
                    mant_y <= mant_y >> 1;
                    d_r    <= d_r - 1'b1;
                    if (d_r == EXP_W'(1))
                        state <= ST_SUB;
                end
                ST_SUB: begin
                    if (sub_mant == '0) begin
                        diff  <= ZERO_WORD;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        mant_r <= sub_mant;
                        exp_r  <= exp_x;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (mant_r[FRAC_W]) begin
                        diff  <= fp_pack(sign_r, exp_r, mant_r[FRAC_W-1:0]);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (exp_r > EXP_W'(1)) begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - 1'b1;
                    end else begin
                        // Would become denormal; this unit flushes to +0 instead.
                        diff  <= ZERO_WORD;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
